pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator at the head of the fetch stage; the next generation of the single-width PC register.
- Generates the instruction-fetch address and the instruction-memory enable.
- Redirect priority: flush (exception/eret) > branch > sequential increment.
- New behaviour:
  - A branch that resolves while fetch is stalled is latched and replayed when the stall releases, instead of being dropped.
  - Instruction-memory backpressure (`fetch_ready`) is honoured.
  - Reset vector, address width and instruction size are configurable.

Parameters:
- ADDR_W, 32, width of PC and all redirect addresses
- INST_BYTES, 4, fetch step in bytes; power of two, 2..8
- RESET_VECTOR, 32'h00000000, first PC issued after reset
- STALL_W, 6, width of pipeline stall vector; bit 0 is the PC stage

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- stall_ctrl  in  STALL_W  pipeline stall vector; only bit 0 is consumed
- fetch_ready  in  1  instruction memory accepts current pc this cycle
- branch_flag  in  1  branch taken, single-cycle pulse from decode/execute
- branch_target_addr  in  ADDR_W  branch destination
- flush  in  1  pipeline flush, single-cycle pulse
- pc_new  in  ADDR_W  flush destination
- pc  out  ADDR_W  current fetch address (registered)
- inst_mem_en  out  1  instruction memory enable, high active (registered)
- redirect_pending  out  1  latched branch waiting for stall release
- misalign_fault  out  1  redirect target misaligned (see Optional Feature)

Behaviour:
- States: IDLE, RUN.
  - rst=1 forces IDLE from any state, including mid-redirect.
  - IDLE -> RUN on the first clock with rst=0.
  - No other transitions.
- Reset/IDLE values:
  - pc=RESET_VECTOR, inst_mem_en=0.
  - Pending register cleared: pend_valid=0, pend_addr=0, so redirect_pending=0.
  - misalign_fault=0.
- First RUN cycle: inst_mem_en=1 and pc still RESET_VECTOR. The first fetch therefore issues at RESET_VECTOR, one cycle after reset release.
- Advance condition: adv = (stall_ctrl[0]==0) && fetch_ready.
- Per-cycle update in RUN, first matching rule wins:
  1. flush=1: pc<=pc_new; pend_valid<=0. Ignores stall, fetch_ready and branch_flag.
  2. pend_valid=1 and adv: pc<=pend_addr; pend_valid<=0. The pending branch is older, so a simultaneous branch_flag is discarded.
  3. pend_valid=1 and !adv: hold pc and pending; new branch_flag is discarded.
  4. branch_flag=1 and adv: pc<=branch_target_addr.
  5. branch_flag=1 and !adv: pc holds; pend_addr<=branch_target_addr; pend_valid<=1.
  6. adv: pc<=pc+INST_BYTES.
  7. Otherwise pc holds.
- Redirect latency: 1 cycle from flag to pc.
- Arithmetic:
  - pc+INST_BYTES wraps modulo 2^ADDR_W; no overflow flag.
  - Low log2(INST_BYTES) bits of pc are always zero.
- inst_mem_en stays 1 throughout RUN, including stalls. Memory is gated by pc hold, not by enable.
- redirect_pending mirrors pend_valid (registered).

Optional Feature:
- Macro: PC_GEN_MISALIGN_CHK_EN
- With the macro:
  - A flush or branch target whose low log2(INST_BYTES) bits are non-zero is not loaded and is not latched pending.
  - pc holds for that cycle; misalign_fault pulses high for exactly one cycle, the cycle after.
  - A pending replay is never misaligned, because latching is already filtered.
- Without the macro:
  - Low log2(INST_BYTES) bits of every target are forced to zero on load.
  - misalign_fault is tied 0; the port remains for interface stability.

Decomposition:
- Shared package/defines (added to the core defines file): `RstEnable`, `InstBusAddrWidth` default, state encodings PCG_IDLE/PCG_RUN, localparam for INST_BYTES log2.
- One natural sub-module: pc_redirect_latch (pend_valid/pend_addr register with load/clear/consume). The remainder stays in pc_gen.

Test Plan (ADDR_W=32, INST_BYTES=4, RESET_VECTOR=32'h0000_0000 unless stated):
- Reset release, no stalls: pc 0x0 for two cycles (inst_mem_en 0 then 1), then 0x4, 0x8, 0xC. With RESET_VECTOR=0xBFC00000, the first fetch is 0xBFC00000.
- stall_ctrl=6'b000001 for 3 cycles starting at pc=0x10, with branch_flag pulse (target 0x200) in stall cycle 2:
  - pc holds 0x10 and redirect_pending=1.
  - Stall release -> pc=0x200 next cycle, then 0x204; redirect_pending clears.
- flush (pc_new=0x180) coincident with branch_flag (0x300) and stall: pc=0x180 next cycle, redirect_pending=0.
- fetch_ready=0 for 2 cycles at pc=0x40: pc holds 0x40, then 0x44. A branch (0x80) during the hold is replayed once fetch_ready=1.
- pc=0xFFFFFFFC, no stall: next pc=0x00000000 (wrap).
- Misaligned branch target 0x102:
  - With PC_GEN_MISALIGN_CHK_EN: pc holds, misalign_fault=1 for one cycle.
  - Without it: pc=0x100, misalign_fault=0.
- rst asserted while redirect_pending=1: next cycle pc=RESET_VECTOR, redirect_pending=0, inst_mem_en=0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch-stage PC generator: reset polarity, default bus width, FSM encodings.
// Pure declarations, no timing and no backpressure of its own.
// Consumers: pc_gen_if, pc_gen, pc_redirect_latch.
package pc_gen_pkg;

    localparam logic RstEnable        = 1'b1;
    localparam int   InstBusAddrWidth = 32;
    localparam int   InstBytesDefault = 4;

    localparam logic [0:0] PCG_IDLE = 1'b0;
    localparam logic [0:0] PCG_RUN  = 1'b1;

    function automatic int inst_bytes_log2(input int bytes);
        return $clog2(bytes);
    endfunction

    localparam int InstBytesLog2 = inst_bytes_log2(InstBytesDefault);

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-address bus between the pipeline control and the PC generator.
// master = PC generator (drives pc/enable), slave = pipeline/memory side.
// Flow control is stall_ctrl[0] plus fetch_ready; no internal storage.
interface pc_gen_if
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W  = InstBusAddrWidth,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall_ctrl;
    logic               fetch_ready;
    logic               branch_flag;
    logic [ADDR_W-1:0]  branch_target_addr;
    logic               flush;
    logic [ADDR_W-1:0]  pc_new;
    logic [ADDR_W-1:0]  pc;
    logic               inst_mem_en;
    logic               redirect_pending;
    logic               misalign_fault;

    modport master (
        input  stall_ctrl, fetch_ready, branch_flag, branch_target_addr, flush, pc_new,
        output pc, inst_mem_en, redirect_pending, misalign_fault
    );

    modport slave (
        output stall_ctrl, fetch_ready, branch_flag, branch_target_addr, flush, pc_new,
        input  pc, inst_mem_en, redirect_pending, misalign_fault
    );
endinterface

// File: rtl/pc_redirect_latch.sv
// Holds one branch target that resolved while fetch could not advance.
// Latency: load/clear visible the cycle after; clear wins over load.
// No backpressure: the caller only loads when nothing is already pending.
module pc_redirect_latch
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = InstBusAddrWidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              clear,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_addr
);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else if (clear) begin
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_valid <= 1'b1;
            pend_addr  <= load_addr;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: flush > pending branch > branch > sequential; PC_GEN_MISALIGN_CHK_EN enables target checks.
// Latency: redirects reach pc one cycle after the flag; first fetch one cycle after reset release.
// Backpressure: pc holds while stall_ctrl[0] or !fetch_ready; a branch in that window is latched and replayed.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W       = InstBusAddrWidth,
    parameter int                INST_BYTES   = InstBytesDefault,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                STALL_W      = 6
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.master bus
);

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);

    logic [0:0]        state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_nxt;
    logic              adv;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_load;
    logic              pend_clear;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] fl_tgt;
    logic              stall_unused;

    assign stall_unused = ^bus.stall_ctrl[STALL_W-1:1];
    assign adv          = !bus.stall_ctrl[0] && bus.fetch_ready;
    assign br_tgt       = bus.branch_target_addr & ALIGN_MASK;
    assign fl_tgt       = bus.pc_new & ALIGN_MASK;

`ifdef PC_GEN_MISALIGN_CHK_EN
    logic fault_nxt;
    logic fault_q;
    logic br_mis;
    logic fl_mis;

    assign br_mis = |(bus.branch_target_addr & ~ALIGN_MASK);
    assign fl_mis = |(bus.pc_new & ~ALIGN_MASK);
`endif

    always_comb begin
        pc_nxt     = pc_q;
        pend_load  = 1'b0;
        pend_clear = 1'b0;
`ifdef PC_GEN_MISALIGN_CHK_EN
        fault_nxt  = 1'b0;
`endif
        if (state_q == PCG_RUN) begin
            if (bus.flush) begin
                // Flush always kills a waiting branch, even if its own target is rejected.
                pend_clear = 1'b1;
`ifdef PC_GEN_MISALIGN_CHK_EN
                if (fl_mis) fault_nxt = 1'b1;
                else        pc_nxt    = fl_tgt;
`else
                pc_nxt = fl_tgt;
`endif
            end else if (pend_valid) begin
                if (adv) begin
                    pc_nxt     = pend_addr;
                    pend_clear = 1'b1;
                end
            end else if (bus.branch_flag) begin
`ifdef PC_GEN_MISALIGN_CHK_EN
                if (br_mis)   fault_nxt = 1'b1;
                else if (adv) pc_nxt    = br_tgt;
                else          pend_load = 1'b1;
`else
                if (adv) pc_nxt    = br_tgt;
                else     pend_load = 1'b1;
`endif
            end else if (adv) begin
                pc_nxt = pc_q + STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= PCG_IDLE;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= PCG_RUN;
            pc_q    <= pc_nxt;
        end
    end

`ifdef PC_GEN_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst == RstEnable) fault_q <= 1'b0;
        else                  fault_q <= fault_nxt;
    end
    assign bus.misalign_fault = fault_q;
`else
    assign bus.misalign_fault = 1'b0;
`endif

    pc_redirect_latch #(.ADDR_W(ADDR_W)) u_latch (
        .clk        (clk),
        .rst        (rst),
        .load       (pend_load),
        .load_addr  (br_tgt),
        .clear      (pend_clear),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr)
    );

    assign bus.pc               = pc_q;
    assign bus.inst_mem_en      = (state_q == PCG_RUN);
    assign bus.redirect_pending = pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic against a queue-based model.
module tb_pc_gen;

    localparam logic [31:0] RV2  = 32'hBFC0_0000;
    localparam logic [31:0] MASK = 32'hFFFF_FFFC;
`ifdef PC_GEN_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus ();
    pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus2 ();

    pc_gen #(.ADDR_W(32), .INST_BYTES(4), .RESET_VECTOR(32'h0), .STALL_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    pc_gen #(.ADDR_W(32), .INST_BYTES(4), .RESET_VECTOR(RV2), .STALL_W(6)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.master)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: the pending branch is a queue of at most one address.
    logic [31:0] m_pc = 32'h0;
    bit          m_run = 1'b0;
    bit          m_fault = 1'b0;
    logic [31:0] pend_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit stall, input bit fr, input bit br, input logic [31:0] bt,
                         input bit fl, input logic [31:0] pn);
        bus.stall_ctrl         = {5'b10100 & 5'($urandom), stall};
        bus.fetch_ready        = fr;
        bus.branch_flag        = br;
        bus.branch_target_addr = bt;
        bus.flush              = fl;
        bus.pc_new             = pn;
    endtask

    function automatic bit misaligned(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

    task automatic model_clock();
        bit adv;
        adv     = !bus.stall_ctrl[0] && bus.fetch_ready;
        m_fault = 1'b0;
        if (rst) begin
            m_run = 1'b0;
            m_pc  = 32'h0;
            pend_q.delete();
        end else if (!m_run) begin
            m_run = 1'b1;
        end else if (bus.flush) begin
            pend_q.delete();
            if (CHK && misaligned(bus.pc_new)) m_fault = 1'b1;
            else                              m_pc = bus.pc_new & MASK;
        end else if (pend_q.size() != 0) begin
            if (adv) m_pc = pend_q.pop_front();
        end else if (bus.branch_flag) begin
            if (CHK && misaligned(bus.branch_target_addr)) m_fault = 1'b1;
            else if (adv) m_pc = bus.branch_target_addr & MASK;
            else          pend_q.push_back(bus.branch_target_addr & MASK);
        end else if (adv) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    // One clock: update model at the edge, compare every output 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_val({tag, ".pc"},    bus.pc,                       m_pc);
        check_val({tag, ".en"},    32'(bus.inst_mem_en),         32'(m_run));
        check_val({tag, ".pend"},  32'(bus.redirect_pending),    32'(pend_q.size() != 0));
        check_val({tag, ".fault"}, 32'(bus.misalign_fault),      32'(m_fault));
    endtask

    initial begin
        bus2.stall_ctrl         = 6'b0;
        bus2.fetch_ready        = 1'b1;
        bus2.branch_flag        = 1'b0;
        bus2.branch_target_addr = 32'h0;
        bus2.flush              = 1'b0;
        bus2.pc_new             = 32'h0;

        // Reset and first fetches
        drive(0, 1, 0, 0, 0, 0);
        rst = 1'b1;
        step("rst0");
        step("rst1");
        check_val("rst_pc", bus.pc, 32'h0);
        check_val("rst_en", 32'(bus.inst_mem_en), 32'h0);
        check_val("rst_pend", 32'(bus.redirect_pending), 32'h0);
        rst = 1'b0;
        step("run0");
        check_val("first_pc", bus.pc, 32'h0);
        check_val("first_en", 32'(bus.inst_mem_en), 32'h1);
        check_val("rv2_first_pc", bus2.pc, RV2);
        check_val("rv2_first_en", 32'(bus2.inst_mem_en), 32'h1);
        step("run1");
        check_val("seq_4", bus.pc, 32'h4);
        check_val("rv2_seq", bus2.pc, RV2 + 32'd4);
        step("run2");
        step("run3");
        check_val("seq_c", bus.pc, 32'hC);
        step("run4");
        check_val("seq_10", bus.pc, 32'h10);

        // Branch during a 3-cycle stall is replayed after release
        drive(1, 1, 0, 0, 0, 0);
        step("stl1");
        drive(1, 1, 1, 32'h200, 0, 0);
        step("stl2");
        check_val("stall_hold", bus.pc, 32'h10);
        check_val("stall_pend", 32'(bus.redirect_pending), 32'h1);
        drive(1, 1, 0, 0, 0, 0);
        step("stl3");
        drive(0, 1, 0, 0, 0, 0);
        step("rel0");
        check_val("replay_pc", bus.pc, 32'h200);
        check_val("replay_pend", 32'(bus.redirect_pending), 32'h0);
        step("rel1");
        check_val("replay_seq", bus.pc, 32'h204);

        // Flush beats branch and stall
        drive(1, 1, 1, 32'h300, 1, 32'h180);
        step("flush");
        check_val("flush_pc", bus.pc, 32'h180);
        check_val("flush_pend", 32'(bus.redirect_pending), 32'h0);

        // fetch_ready backpressure
        drive(0, 1, 0, 0, 1, 32'h40);
        step("fr_set");
        drive(0, 0, 0, 0, 0, 0);
        step("fr_h1");
        step("fr_h2");
        check_val("fr_hold", bus.pc, 32'h40);
        drive(0, 1, 0, 0, 0, 0);
        step("fr_go");
        check_val("fr_seq", bus.pc, 32'h44);
        drive(0, 0, 1, 32'h80, 0, 0);
        step("fr_br");
        check_val("fr_br_hold", bus.pc, 32'h44);
        drive(0, 1, 0, 0, 0, 0);
        step("fr_rep");
        check_val("fr_replay", bus.pc, 32'h80);

        // Wrap at top of address space
        drive(0, 1, 0, 0, 1, 32'hFFFF_FFFC);
        step("wrap0");
        drive(0, 1, 0, 0, 0, 0);
        step("wrap1");
        check_val("wrap_pc", bus.pc, 32'h0);

        // Misaligned branch target
        drive(0, 1, 1, 32'h102, 0, 0);
        step("mis");
`ifdef PC_GEN_MISALIGN_CHK_EN
        check_val("mis_pc", bus.pc, 32'h0);
        check_val("mis_fault", 32'(bus.misalign_fault), 32'h1);
        drive(0, 1, 0, 0, 0, 0);
        step("mis1");
        check_val("mis_fault_clr", 32'(bus.misalign_fault), 32'h0);
`else
        check_val("mis_pc", bus.pc, 32'h100);
        check_val("mis_fault", 32'(bus.misalign_fault), 32'h0);
`endif

        // Reset while a branch is pending
        drive(1, 1, 1, 32'h500, 0, 0);
        step("prst0");
        check_val("prst_pend", 32'(bus.redirect_pending), 32'h1);
        drive(1, 1, 0, 0, 0, 0);
        rst = 1'b1;
        step("prst1");
        check_val("prst_pc", bus.pc, 32'h0);
        check_val("prst_pend_clr", 32'(bus.redirect_pending), 32'h0);
        check_val("prst_en", 32'(bus.inst_mem_en), 32'h0);
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] bt;
            logic [31:0] pn;
            bt = $urandom & 32'h0000_FFFF;
            pn = $urandom;
            if ($urandom_range(3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(3) != 0) pn[1:0] = 2'b00;
            drive($urandom_range(2) == 0, $urandom_range(3) != 0, $urandom_range(4) == 0, bt,
                  $urandom_range(15) == 0, pn);
            rst = ($urandom_range(199) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
